// File: rtl/aibcr3_tx_pkg.sv
// ============================================================================
// Module : aibcr3_tx_pkg
// Desc   : Mode encodings and sequencer states shared by the AIB TX/RX datapaths
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package aibcr3_tx_pkg;

  localparam logic [2:0] MODE_ASYNC = 3'b000;
  localparam logic [2:0] MODE_DDR   = 3'b001;
  localparam logic [2:0] MODE_DIS   = 3'b010;
  localparam logic [2:0] MODE_CLK   = 3'b011;
  localparam logic [2:0] MODE_SDR   = 3'b100;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2
  } tx_state_e;

  // Reserved codes 101/110/111 behave exactly like the explicit disable code.
  function automatic logic mode_is_dis(input logic [2:0] mode);
    return !(mode == MODE_ASYNC || mode == MODE_DDR ||
             mode == MODE_CLK   || mode == MODE_SDR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aibcr3_txdig_ser_if.sv
// ============================================================================
// Module : aibcr3_txdig_ser_if
// Desc   : Core-side control/data and pad-side outputs of one AIB TX lane
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aibcr3_txdig_ser_if;
  logic [2:0] itxen;
  logic       idat0;
  logic       idat1;
  logic       tx_dat;
  logic       tx_oe;
  logic       tx_ready;
  logic [2:0] tx_mode;

  modport master (
    output itxen, idat0, idat1,
    input  tx_dat, tx_oe, tx_ready, tx_mode
  );

  modport slave (
    input  itxen, idat0, idat1,
    output tx_dat, tx_oe, tx_ready, tx_mode
  );
endinterface

`default_nettype wire

// File: rtl/aibcr3_txdig_clkmux.sv
// ============================================================================
// Module : aibcr3_txdig_clkmux
// Desc   : Clock-level 2:1 data mux and negedge-retimed clock gate
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aibcr3_txdig_clkmux (
  input  wire logic clk_i,
  input  wire logic rst_n_i,
  input  wire logic hi_i,
  input  wire logic lo_i,
  input  wire logic gate_en_i,
  output logic      mux_o,
  output logic      gclk_o
);

  logic en_q;

  // Enable only moves while the clock is low, so the gated output never
  // starts or ends a high phase early.
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) en_q <= 1'b0;
    else          en_q <= gate_en_i;
  end

  assign mux_o  = clk_i ? hi_i : lo_i;
  assign gclk_o = clk_i & en_q;

endmodule

`default_nettype wire

// File: rtl/aibcr3_txdig_ser.sv
// ============================================================================
// Module : aibcr3_txdig_ser
// Desc   : AIB TX serializer (async/DDR/SDR/clock-forward) with OE sequencer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module aibcr3_txdig_ser
  import aibcr3_tx_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 3
) (
  input  wire logic           iclkin_dist,
  input  wire logic           irstb,
  aibcr3_txdig_ser_if.slave   bus
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       sync_q;
  logic [2:0]       mode_q;
  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             oe_q;
  logic             rdy_q;
  logic             p0_q, p1_q;
  logic             q0_q, q1h_q, q1_q;
  logic             mux_w, gclk_w, gate_en_w, tx_dat_w;

  // Sequencer: a mode change or unsynchronized reset always forces OFF.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      sync_q  <= 2'b00;
      mode_q  <= MODE_DIS;
      state_q <= OFF;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      mode_q <= bus.itxen;
      if (!sync_q[1] || (bus.itxen != mode_q)) begin
        state_q <= OFF;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        rdy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          OFF: begin
            cnt_q <= '0;
            if (!mode_is_dis(mode_q)) begin
              state_q <= SETTLE;
              oe_q    <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt_q == C_CNT_LAST) begin
              state_q <= ACTIVE;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ACTIVE: begin
            rdy_q <= 1'b1;
          end
          default: begin
            state_q <= OFF;
            oe_q    <= 1'b0;
            rdy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // q1 is staged once more than q0 so the low-phase bit trails the high-phase bit.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      p0_q  <= 1'b0;
      p1_q  <= 1'b0;
      q0_q  <= 1'b0;
      q1h_q <= 1'b0;
    end else begin
      p0_q  <= (state_q == ACTIVE) & bus.idat0;
      p1_q  <= (state_q == ACTIVE) & bus.idat1;
      q0_q  <= p0_q;
      q1h_q <= p1_q;
    end
  end

  always_ff @(negedge iclkin_dist or negedge irstb) begin
    if (!irstb) q1_q <= 1'b0;
    else        q1_q <= q1h_q;
  end

  assign gate_en_w = rdy_q & (mode_q == MODE_CLK);

  aibcr3_txdig_clkmux u_clkmux (
    .clk_i     (iclkin_dist),
    .rst_n_i   (irstb),
    .hi_i      (q0_q),
    .lo_i      (q1_q),
    .gate_en_i (gate_en_w),
    .mux_o     (mux_w),
    .gclk_o    (gclk_w)
  );

  always_comb begin
    tx_dat_w = 1'b0;
    case (mode_q)
      MODE_ASYNC: tx_dat_w = bus.idat0 & rdy_q;
      MODE_DDR:   tx_dat_w = mux_w & rdy_q;
      MODE_SDR:   tx_dat_w = q0_q & rdy_q;
      MODE_CLK:   tx_dat_w = gclk_w;
      default:    tx_dat_w = 1'b0;
    endcase
  end

  assign bus.tx_dat   = tx_dat_w;
  assign bus.tx_oe    = oe_q;
  assign bus.tx_ready = rdy_q;
  assign bus.tx_mode  = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3_txdig_ser.sv
// ============================================================================
// Module : tb_aibcr3_txdig_ser
// Desc   : Directed self-checking bench for the AIB TX serializer
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aibcr3_txdig_ser;

  logic clk;
  logic rstb;
  int   n_chk;
  int   n_pass;

  aibcr3_txdig_ser_if bus ();

  aibcr3_txdig_ser #(.SETTLE_CYC(4), .CNT_W(3)) dut (
    .iclkin_dist (clk),
    .irstb       (rstb),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", tag, got, exp);
  endtask

  // Returns 1ns after the next rising edge (clock-high phase).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full power-up sequence from reset release: OFF x2 sync, OFF x1, SETTLE x4.
  task automatic release_and_settle(input string tag);
    rstb = 1'b1;
    step(); check({tag, "_sync1_oe"}, {2'b0, bus.tx_oe}, 3'd0);
    step(); check({tag, "_sync2_oe"}, {2'b0, bus.tx_oe}, 3'd0);
    step(); check({tag, "_settle_oe"}, {2'b0, bus.tx_oe}, 3'd1);
    check({tag, "_settle_rdy"}, {2'b0, bus.tx_ready}, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check({tag, "_settle_dat"}, {2'b0, bus.tx_dat}, 3'd0);
      check({tag, "_settle_rdy"}, {2'b0, bus.tx_ready}, 3'd0);
    end
    step(); check({tag, "_active_rdy"}, {2'b0, bus.tx_ready}, 3'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstb      = 1'b0;
    bus.itxen = 3'b001;
    bus.idat0 = 1'b0;
    bus.idat1 = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_oe",   {2'b0, bus.tx_oe},    3'd0);
    check("rst_dat",  {2'b0, bus.tx_dat},   3'd0);
    check("rst_rdy",  {2'b0, bus.tx_ready}, 3'd0);
    check("rst_mode", bus.tx_mode,          3'b010);
    release_and_settle("pwr");

    // DDR stream (1,0),(0,1),(1,1)
    bus.idat0 = 1'b1; bus.idat1 = 1'b0;
    step(); bus.idat0 = 1'b0; bus.idat1 = 1'b1;
    step(); bus.idat0 = 1'b1; bus.idat1 = 1'b1;
    check("ddr0_hi", {2'b0, bus.tx_dat}, 3'd1);
    #5 check("ddr0_lo", {2'b0, bus.tx_dat}, 3'd0);
    step(); bus.idat0 = 1'b0; bus.idat1 = 1'b0;
    check("ddr1_hi", {2'b0, bus.tx_dat}, 3'd0);
    #5 check("ddr1_lo", {2'b0, bus.tx_dat}, 3'd1);
    step();
    check("ddr2_hi", {2'b0, bus.tx_dat}, 3'd1);
    #5 check("ddr2_lo", {2'b0, bus.tx_dat}, 3'd1);

    // Mode change DDR -> SDR mid-stream
    bus.itxen = 3'b100; bus.idat0 = 1'b1;
    step();
    check("sdr_off_oe",   {2'b0, bus.tx_oe}, 3'd0);
    check("sdr_off_dat",  {2'b0, bus.tx_dat}, 3'd0);
    check("sdr_off_mode", bus.tx_mode, 3'b100);
    for (int i = 0; i < 4; i++) begin
      step();
      check("sdr_settle_oe",  {2'b0, bus.tx_oe},  3'd1);
      check("sdr_settle_dat", {2'b0, bus.tx_dat}, 3'd0);
    end
    step();
    check("sdr_rdy", {2'b0, bus.tx_ready}, 3'd1);
    check("sdr_first_dat", {2'b0, bus.tx_dat}, 3'd0);
    step(); bus.idat0 = 1'b0; bus.idat1 = 1'b1;
    check("sdr_lat_dat", {2'b0, bus.tx_dat}, 3'd0);
    step();
    check("sdr_bit_hi", {2'b0, bus.tx_dat}, 3'd1);
    #5 check("sdr_bit_lo", {2'b0, bus.tx_dat}, 3'd1);
    step();
    check("sdr_idat1_ign", {2'b0, bus.tx_dat}, 3'd0);

    // Clock forward
    bus.itxen = 3'b011; bus.idat1 = 1'b0;
    repeat (6) step();
    check("clk_rdy",    {2'b0, bus.tx_ready}, 3'd1);
    check("clk_pre_hi", {2'b0, bus.tx_dat},   3'd0);
    #5 check("clk_pre_lo", {2'b0, bus.tx_dat}, 3'd0);
    step();
    check("clk_p1_hi", {2'b0, bus.tx_dat}, 3'd1);
    #3 check("clk_p1_hi2", {2'b0, bus.tx_dat}, 3'd1);
    #2 check("clk_p1_lo", {2'b0, bus.tx_dat}, 3'd0);
    step();
    check("clk_p2_hi", {2'b0, bus.tx_dat}, 3'd1);
    #5 bus.itxen = 3'b010;
    step();
    check("dis_oe", {2'b0, bus.tx_oe}, 3'd0);
    #5 check("dis_lo", {2'b0, bus.tx_dat}, 3'd0);
    step();
    check("dis_hi",  {2'b0, bus.tx_dat},   3'd0);
    check("dis_rdy", {2'b0, bus.tx_ready}, 3'd0);

    // Async, combinational follow mid-cycle
    bus.itxen = 3'b000;
    repeat (6) step();
    check("async_rdy", {2'b0, bus.tx_ready}, 3'd1);
    bus.idat0 = 1'b1; #1 check("async_1", {2'b0, bus.tx_dat}, 3'd1);
    bus.idat0 = 1'b0; #1 check("async_0", {2'b0, bus.tx_dat}, 3'd0);
    #4 bus.idat0 = 1'b1; #1 check("async_lo_1", {2'b0, bus.tx_dat}, 3'd1);

    // Reserved code behaves as disable
    bus.itxen = 3'b111;
    step();
    check("rsv_oe",   {2'b0, bus.tx_oe},    3'd0);
    check("rsv_rdy",  {2'b0, bus.tx_ready}, 3'd0);
    check("rsv_dat",  {2'b0, bus.tx_dat},   3'd0);
    check("rsv_mode", bus.tx_mode, 3'b111);
    step();
    check("rsv_stay_oe", {2'b0, bus.tx_oe}, 3'd0);

    // Reset during SETTLE at counter=2
    bus.itxen = 3'b001; bus.idat0 = 1'b0;
    repeat (4) step();
    check("mid_settle_oe", {2'b0, bus.tx_oe}, 3'd1);
    rstb = 1'b0;
    #1;
    check("arst_oe",   {2'b0, bus.tx_oe},    3'd0);
    check("arst_rdy",  {2'b0, bus.tx_ready}, 3'd0);
    check("arst_mode", bus.tx_mode,          3'b010);
    repeat (2) step();
    release_and_settle("rel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
